// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TX_ADDR push a byte into a FIFO that the
// serialiser drains; stores to CTRL_ADDR with bit 0 set clear the sticky overflow flag.
module mmio_uart_tx #(
  parameter logic [31:0] TX_ADDR      = 32'h0000_00F0,
  parameter logic [31:0] CTRL_ADDR    = 32'h0000_00F4,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [31:0]              DataAdr,
  input  logic [31:0]              WriteData,
  output logic                     tx,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CNW = AW + 1;
  localparam int unsigned BW  = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNW-1:0] count_q, count_d;
  logic           full_q, empty_q, ovf_q, ovf_d;
  logic [1:0]     state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           push_req, push_ok, pop, ovf_set, ovf_clr, baud_tc;
  logic           unused_wdata;

  assign unused_wdata = ^WriteData[31:8];

  assign push_req = MemWrite && (DataAdr == TX_ADDR);
  assign ovf_clr  = MemWrite && (DataAdr == CTRL_ADDR) && WriteData[0];
  assign pop      = (state_q == ST_IDLE) && !empty_q;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full_q || pop);
  assign ovf_set  = push_req && full_q && !pop;
  assign baud_tc  = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNW'(1);
      2'b01:   count_d = count_q - CNW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q) begin
          shift_d = mem[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_tc) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_tc) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // tx is registered from the next state so the line changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= WriteData[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNW'(DEPTH));
      empty_q  <= (count_d == '0);
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE);
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, DEPTH=4; the tx line is logged
// every cycle and decoded into frames afterwards.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        tx, busy, full, empty, overflow;
  logic [2:0]  count;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .TX_ADDR     (32'h0000_00F0),
    .CTRL_ADDR   (32'h0000_00F4),
    .DEPTH       (4),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .DataAdr  (DataAdr),
    .WriteData(WriteData),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [2:0]  exp_count;
    logic        exp_tx;
    logic        exp_ovf;
  } vec_t;

  vec_t        vecs[6];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        txlog[$];
  logic        busylog[$];
  logic [7:0]  rx_bytes[$];
  int          rx_starts[$];
  int          rx_bad;
  int          ones;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    txlog.push_back(tx);
    busylog.push_back(busy);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic store(input logic we, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = we;
    DataAdr   = a;
    WriteData = d;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic clear_logs();
    txlog.delete();
    busylog.delete();
  endtask

  // Frames are 40 samples: start, 8 data bits LSB first, stop; each bit held 4 cycles.
  task automatic decode();
    int         idx;
    logic [7:0] b;
    idx = 0;
    rx_bytes.delete();
    rx_starts.delete();
    rx_bad = 0;
    while (idx < txlog.size()) begin
      if (txlog[idx] === 1'b0 && (idx == 0 || txlog[idx-1] === 1'b1)) begin
        if (idx + 40 > txlog.size()) begin
          rx_bad++;
          break;
        end
        for (int k = 0; k < 10; k++)
          for (int m = 1; m < 4; m++)
            if (txlog[idx+4*k+m] !== txlog[idx+4*k]) rx_bad++;
        if (txlog[idx+36] !== 1'b1) rx_bad++;
        for (int j = 0; j < 8; j++) b[j] = txlog[idx+4*(j+1)];
        rx_bytes.push_back(b);
        rx_starts.push_back(idx);
        idx += 40;
      end else begin
        idx++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{we: 1'b1, adr: 32'h0000_00EC, wd: 32'h0000_00FE, exp_count: 3'd0, exp_tx: 1'b1,
                exp_ovf: 1'b0};
    vecs[1] = '{we: 1'b1, adr: 32'h0000_00F1, wd: 32'h0000_00FE, exp_count: 3'd0, exp_tx: 1'b1,
                exp_ovf: 1'b0};
    vecs[2] = '{we: 1'b1, adr: 32'h0000_00F4, wd: 32'h0000_00FE, exp_count: 3'd0, exp_tx: 1'b1,
                exp_ovf: 1'b0};
    vecs[3] = '{we: 1'b0, adr: 32'h0000_00F0, wd: 32'h0000_00FE, exp_count: 3'd0, exp_tx: 1'b1,
                exp_ovf: 1'b0};
    vecs[4] = '{we: 1'b1, adr: 32'h0001_00F0, wd: 32'h0000_00FE, exp_count: 3'd0, exp_tx: 1'b1,
                exp_ovf: 1'b0};
    vecs[5] = '{we: 1'b1, adr: 32'h8000_00F0, wd: 32'h0000_00FE, exp_count: 3'd0, exp_tx: 1'b1,
                exp_ovf: 1'b0};

    reset     = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = 32'h0;
    WriteData = 32'h0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("reset_tx", tx, 1);
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_count", count, 0);
    check("reset_overflow", overflow, 0);
    check("reset_busy", busy, 0);

    // Single byte
    clear_logs();
    store(1'b1, 32'h0000_00F0, 32'h0000_0055);
    check("single_count_push", count, 1);
    check("single_empty_push", empty, 0);
    check("single_tx_before_start", tx, 1);
    tick();
    check("single_count_pop", count, 0);
    check("single_tx_fall", tx, 0);
    check("single_busy_rise", busy, 1);
    idle(48);
    decode();
    check("single_nframes", rx_bytes.size(), 1);
    check("single_byte", rx_bytes.size() > 0 ? rx_bytes[0] : 8'hxx, 8'h55);
    check("single_start_idx", rx_starts.size() > 0 ? rx_starts[0] : -1, 1);
    check("single_frame_shape", rx_bad, 0);
    check("single_busy_last", busylog[40], 1);
    check("single_busy_fall", busylog[41], 0);

    // Burst fills the FIFO mid-frame, then overflow and its clear
    clear_logs();
    store(1'b1, 32'h0000_00F0, 32'h41);
    check("burst_count1", count, 1);
    store(1'b1, 32'h0000_00F0, 32'h42);
    check("burst_tx_fall", tx, 0);
    check("burst_count_pushpop", count, 1);
    store(1'b1, 32'h0000_00F0, 32'h43);
    check("burst_count2", count, 2);
    store(1'b1, 32'h0000_00F0, 32'h44);
    check("burst_count3", count, 3);
    store(1'b1, 32'h0000_00F0, 32'h45);
    check("burst_count4", count, 4);
    check("burst_full", full, 1);
    check("burst_no_overflow", overflow, 0);
    store(1'b1, 32'h0000_00F0, 32'h99);
    check("ovf_set", overflow, 1);
    check("ovf_count_held", count, 4);
    store(1'b1, 32'h0000_00F4, 32'hFE);
    check("ovf_clear_bit0_zero", overflow, 1);
    store(1'b1, 32'h0000_00F4, 32'h01);
    check("ovf_cleared", overflow, 0);
    check("ovf_clear_count", count, 4);
    idle(220);
    decode();
    check("burst_nframes", rx_bytes.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("burst_byte%0d", i), i < rx_bytes.size() ? rx_bytes[i] : 8'hxx,
            8'h41 + 8'(i));
      check($sformatf("burst_start%0d", i), i < rx_starts.size() ? rx_starts[i] : -1,
            1 + 41 * i);
    end
    check("burst_frame_shape", rx_bad, 0);
    check("burst_end_empty", empty, 1);
    check("burst_end_busy", busy, 0);

    // Address decode table
    clear_logs();
    foreach (vecs[i]) begin
      store(vecs[i].we, vecs[i].adr, vecs[i].wd);
      check($sformatf("decode%0d_count", i), count, vecs[i].exp_count);
      check($sformatf("decode%0d_tx", i), tx, vecs[i].exp_tx);
      check($sformatf("decode%0d_ovf", i), overflow, vecs[i].exp_ovf);
    end
    idle(10);
    ones = 0;
    foreach (txlog[i]) if (txlog[i] === 1'b1) ones++;
    check("decode_tx_idle", ones, txlog.size());
    check("decode_busy", busy, 0);

    // Reset during data bit 3 with two bytes queued
    clear_logs();
    store(1'b1, 32'h0000_00F0, 32'hA5);
    store(1'b1, 32'h0000_00F0, 32'h3C);
    store(1'b1, 32'h0000_00F0, 32'hC3);
    check("midrst_count_queued", count, 2);
    idle(15);
    check("midrst_in_bit3", txlog[17], 0);
    check("midrst_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_count", count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_empty", empty, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_logs();
    idle(60);
    ones = 0;
    foreach (txlog[i]) if (txlog[i] === 1'b1) ones++;
    check("midrst_no_frame", ones, txlog.size());
    check("midrst_count_after", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped serial output port on the data-memory side of the single-cycle processor. It decodes stores from the core (`MemWrite`, `DataAdr`, `WriteData`) to one fixed address and pushes the low byte into a FIFO. An 8N1 UART transmitter drains the FIFO, so a program can print characters without stalling. The block sits in parallel with `dmem` in the top level, taps the same store bus, and never drives `ReadData`.

## Interface
Clock and reset: one clock; reset is asynchronous and active-low. The ports are named `clk` and `reset`.

Parameters:
- `TX_ADDR`, default 32'h0000_00F0: byte address of the transmit data register.
- `CTRL_ADDR`, default 32'h0000_00F4: control address; a store with `WriteData[0]`=1 clears `overflow`.
- `DEPTH`, default 8: FIFO entries; must be a power of two and at least 2.
- `CLKS_PER_BIT`, default 16: `clk` cycles per UART bit; must be at least 2.

Ports:
- `clk`, input, 1: rising-edge clock shared with the core.
- `reset`, input, 1: asynchronous, active-low; asserted when 0.
- `MemWrite`, input, 1: store strobe from the core.
- `DataAdr`, input, 32: store address.
- `WriteData`, input, 32: store data; only `[7:0]` is used.
- `tx`, output, 1: serial line, idle high, registered.
- `busy`, output, 1: high while a frame is in progress (state is not IDLE).
- `full`, output, 1: FIFO count equals `DEPTH`.
- `empty`, output, 1: FIFO count equals 0.
- `count`, output, clog2(DEPTH)+1: number of bytes in the FIFO.
- `overflow`, output, 1: sticky flag; a push was dropped because the FIFO was full.

## Operation
- Push condition: `MemWrite`=1 and `DataAdr`==`TX_ADDR`. An exact 32-bit compare is required.
- Push effect: `WriteData[7:0]` is written at the write pointer.
- Full behaviour: if the FIFO is full and no pop occurs in the same cycle, the byte is dropped, `overflow` is set and the FIFO is unchanged.
- Overflow clear: a store to `CTRL_ADDR` with `WriteData[0]`=1 clears `overflow`. If a set and a clear land in the same cycle, set wins.
- Stores to any other address are ignored.
- FIFO structure: a circular buffer with clog2(DEPTH)-bit read and write pointers that wrap modulo `DEPTH`, plus a separate counter.
  - Simultaneous push and pop: `count` is unchanged, both pointers advance, and the push is accepted even when the FIFO is full.
- TX state machine, states IDLE, START, DATA, STOP:
  - **IDLE:** `tx`=1. If `!empty`, pop the head into an 8-bit shift register, clear the baud counter and bit index, and go to START.
  - **START:** `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - **DATA:** `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit, shifting right after each bit. After 8 bits (LSB first) go to STOP.
  - **STOP:** `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1; reaching terminal count advances the bit or state.
- Reset mid-frame: the frame is aborted immediately, `tx` returns to 1, and the FIFO contents are discarded.

## Timing
- Reset values: `tx`=1, `busy`=0, `full`=0, `empty`=1, `count`=0, `overflow`=0, state IDLE, pointers 0.
- Push latency: a store sampled at edge E0 updates `count`, `empty` and `full` immediately after E0.
- Frame start latency:
  - With the FIFO empty at E0, the pop happens at edge E1 (the next edge).
  - `tx` falls and `busy` rises after E1, and `count` decrements after E1.
  - Start latency is therefore 1 cycle after the store edge.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles from the `tx` fall to the return to IDLE.
- Back-to-back frames: IDLE occupies exactly 1 cycle between frames while the FIFO is non-empty. The frame period is 10×`CLKS_PER_BIT`+1 cycles.
- Flags: `full`, `empty`, `count` and `busy` are registered. `busy` is derived from the state register with no combinational path from the inputs.
- Store bus: a single-cycle pulse per store, matching the single-cycle core. Consecutive-cycle stores each push one byte.

## Test plan
Use `CLKS_PER_BIT`=4 and `DEPTH`=4 throughout.
1. **Reset:** hold `reset`=0 for 3 cycles, then release. Required: `tx`=1, `empty`=1, `count`=0, `overflow`=0, `busy`=0.
2. **Single byte:** one store of 32'h0000_0055 to 0xF0. Required:
   - `count` goes to 1, then to 0 one cycle later.
   - `tx` sequence, 4 cycles each: 0, then 1,0,1,0,1,0,1,0, then 1.
   - `busy` falls 40 cycles after the `tx` fall.
3. **Burst and full:** 5 stores on consecutive cycles, 0x41..0x45, while idle. Required:
   - First byte pops after 1 cycle; 4 bytes are queued and `full`=1.
   - Exactly one more push is accepted or dropped according to the push/pop timing, with `overflow`=0 if every push was accepted.
   - The line carries 0x41, 0x42, 0x43, 0x44, 0x45 in order with a 41-cycle frame period.
4. **Overflow:** fill the FIFO mid-frame, then store 0x99. Required:
   - `overflow`=1, `count` stays 4, and 0x99 never appears on `tx`.
   - A store of 1 to 0xF4 then clears `overflow`.
5. **Address decode:** stores to 0xEC, 0xF1 and 0xF4 (data 0xFE), plus `MemWrite`=0 with `DataAdr`=0xF0. Required: `count` stays 0 and `tx` stays 1.
6. **Reset mid-frame:** assert `reset` during the DATA bit 3 period with 2 bytes queued. Required: `tx`=1 immediately, `count`=0, and no frame after release.
